// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Brief    : Round-robin arbiter handing one byte per frame from NUM_REQ
//            producers to a single UART transmitter, tracking its Busy flag.
//            Optional WAIT_BUSY watchdog: define UART_TX_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================

module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          tx_busy_i,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  output logic                          tx_data_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          sched_busy_o,
  output logic                          timeout_err_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] c_st_idle      = 2'd0;
  localparam logic [1:0] c_st_issue     = 2'd1;
  localparam logic [1:0] c_st_wait_busy = 2'd2;
  localparam logic [1:0] c_st_wait_done = 2'd3;

  logic [1:0]            state_q,         state_d;
  logic [IDX_W-1:0]      ptr_q,           ptr_d;
  logic [IDX_W-1:0]      grant_id_q,      grant_id_d;
  logic [DATA_WIDTH-1:0] tx_data_q,       tx_data_d;
  logic                  tx_data_valid_q, tx_data_valid_d;
  logic [NUM_REQ-1:0]    req_ready_q,     req_ready_d;
  logic                  sched_busy_q,    sched_busy_d;

  logic                  w_found;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic [IDX_W:0]        w_rr_idx;
  logic [DATA_WIDTH-1:0] w_req_bytes [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_bytes[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search from ptr upward, wrapping modulo NUM_REQ; the sum fits IDX_W+1 bits.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_rr_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rr_idx = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (w_rr_idx >= (IDX_W+1)'(NUM_REQ)) begin
        w_rr_idx = w_rr_idx - (IDX_W+1)'(NUM_REQ);
      end
      if (!w_found && req_valid_i[w_rr_idx[IDX_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_rr_idx[IDX_W-1:0];
      end
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    grant_id_d      = grant_id_q;
    tx_data_d       = tx_data_q;
    tx_data_valid_d = 1'b0;
    req_ready_d     = '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    cnt_d           = cnt_q;
    timeout_err_d   = 1'b0;
`endif
    case (state_q)
      c_st_idle: begin
        if (w_found && !tx_busy_i) begin
          state_d                = c_st_issue;
          tx_data_d              = w_req_bytes[w_gnt_idx];
          grant_id_d             = w_gnt_idx;
          ptr_d                  = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
          tx_data_valid_d        = 1'b1;
          req_ready_d[w_gnt_idx] = 1'b1;
        end
      end
      c_st_issue: begin
        state_d = c_st_wait_busy;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      c_st_wait_busy: begin
        if (tx_busy_i) begin
          state_d = c_st_wait_done;
        end
`ifdef UART_TX_SCHED_TIMEOUT_EN
        // The count reaching TIMEOUT_CYCLES abandons the byte; ptr already moved on.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = c_st_idle;
          timeout_err_d = 1'b1;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      c_st_wait_done: begin
        if (!tx_busy_i) begin
          state_d = c_st_idle;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
    sched_busy_d = (state_d != c_st_idle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= c_st_idle;
      ptr_q           <= '0;
      grant_id_q      <= '0;
      tx_data_q       <= '0;
      tx_data_valid_q <= 1'b0;
      req_ready_q     <= '0;
      sched_busy_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      grant_id_q      <= grant_id_d;
      tx_data_q       <= tx_data_d;
      tx_data_valid_q <= tx_data_valid_d;
      req_ready_q     <= req_ready_d;
      sched_busy_q    <= sched_busy_d;
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err_o = timeout_err_q;
`else
  assign timeout_err_o = 1'b0;
`endif

  assign req_ready_o     = req_ready_q;
  assign tx_data_o       = tx_data_q;
  assign tx_data_valid_o = tx_data_valid_q;
  assign grant_id_o      = grant_id_q;
  assign sched_busy_o    = sched_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Brief    : Directed and randomized bench for uart_tx_scheduler against a
//            frame-level round-robin/transmitter-timing reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_uart_tx_scheduler;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int TOUT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          tx_busy;
  logic [DW-1:0] tx_data;
  logic          tx_data_valid;
  logic [1:0]    grant_id;
  logic          sched_busy;
  logic          timeout_err;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ       (N),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready),
    .tx_busy_i      (tx_busy),
    .tx_data_o      (tx_data),
    .tx_data_valid_o(tx_data_valid),
    .grant_id_o     (grant_id),
    .sched_busy_o   (sched_busy),
    .timeout_err_o  (timeout_err)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Stimulus state
  logic         drv_rst    = 1'b1;
  logic [N-1:0] req_v      = '0;
  logic [DW-1:0] req_d [N];
  logic [N-1:0] hold_mask  = '0;
  logic         force_busy = 1'b0;
  int           next_len   = 3;

  // Inputs as applied to the upcoming edge
  logic         p_rst;
  logic [N-1:0] p_valid;
  logic [DW-1:0] p_data [N];
  logic         p_busy;

  // Reference model: round-robin pointer plus frame timing windows
  int           m_ptr      = 0;
  int           m_gid      = 0;
  logic [DW-1:0] m_data    = '0;
  bit           m_inflight = 1'b0;
  int           m_end      = -1;
  int           m_free_at  = 0;
  int           m_busy_from = -1;
  int           m_busy_to   = -1;
  int           m_tout_at   = -1;

  int seen_gnt [$];
  int seen_dat [$];
  int seen_cyc [$];
  int tout_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic step();
    logic         exp_strobe;
    logic [N-1:0] exp_ready;
    logic         exp_sb;
    logic         exp_tout;
    int           w;
    rst       = drv_rst;
    req_valid = req_v;
    req_data  = {req_d[3], req_d[2], req_d[1], req_d[0]};
    tx_busy   = force_busy || (cyc >= m_busy_from && cyc <= m_busy_to);
    p_rst     = drv_rst;
    p_valid   = req_v;
    for (int i = 0; i < N; i++) p_data[i] = req_d[i];
    p_busy    = tx_busy;

    @(posedge clk);
    #1;
    cyc++;

    exp_strobe = 1'b0;
    exp_ready  = '0;
    exp_tout   = 1'b0;
    if (p_rst) begin
      m_ptr = 0; m_gid = 0; m_data = '0; m_inflight = 1'b0;
      m_free_at = cyc + 1; m_busy_from = -1; m_busy_to = -1; m_tout_at = -1;
      exp_sb = 1'b0;
    end else begin
      if (m_inflight && cyc > m_end) m_inflight = 1'b0;
      if (!m_inflight && cyc >= m_free_at && p_valid != '0 && !p_busy) begin
        w = rr_pick(p_valid, m_ptr);
        exp_strobe        = 1'b1;
        exp_ready[w[1:0]] = 1'b1;
        m_gid      = w;
        m_data     = p_data[w[1:0]];
        m_ptr      = (w + 1) % N;
        m_inflight = 1'b1;
        if (next_len > 0) begin
          m_busy_from = cyc + 1;
          m_busy_to   = cyc + next_len;
          m_end       = cyc + next_len + 1;
          m_tout_at   = -1;
        end else begin
          m_busy_from = -1;
          m_busy_to   = -1;
          m_end       = cyc + TOUT;
          m_tout_at   = cyc + TOUT + 1;
        end
        m_free_at = m_end + 2;
        req_v[w[1:0]] = hold_mask[w[1:0]];
        if (hold_mask[w[1:0]]) req_d[w[1:0]] = 8'($urandom);
      end
      exp_tout = (cyc == m_tout_at);
      exp_sb   = m_inflight;
    end

    chk("tx_data_valid", 32'(tx_data_valid), 32'(exp_strobe));
    chk("req_ready",     32'(req_ready),     32'(exp_ready));
    chk("grant_id",      32'(grant_id),      32'(m_gid));
    chk("tx_data",       32'(tx_data),       32'(m_data));
    chk("sched_busy",    32'(sched_busy),    32'(exp_sb));
    chk("timeout_err",   32'(timeout_err),   32'(exp_tout));

    if (tx_data_valid === 1'b1) begin
      seen_gnt.push_back(int'(grant_id));
      seen_dat.push_back(int'(tx_data));
      seen_cyc.push_back(cyc);
    end
    if (timeout_err === 1'b1) tout_cyc = cyc;
  endtask

  task automatic wait_grant(input int bound);
    int n0;
    int k;
    n0 = seen_gnt.size();
    k  = 0;
    while (seen_gnt.size() == n0 && k < bound) begin
      step();
      k++;
    end
    chk("grant_wait", 32'(seen_gnt.size() > n0), 32'd1);
  endtask

  task automatic do_reset();
    drv_rst = 1'b1;
    step();
    step();
    drv_rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) req_d[i] = '0;

    // Reset, then one requester with a long transmitter frame
    do_reset();
    req_v    = 4'b0001;
    req_d[0] = 8'hA5;
    next_len = 11;
    wait_grant(10);
    repeat (16) step();
    chk("single_count", 32'(seen_gnt.size()), 32'd1);
    chk("single_gid",   32'(seen_gnt[0]),     32'd0);
    chk("single_data",  32'(seen_dat[0]),     32'hA5);

    // All four valid, each dropping after its ready
    do_reset();
    seen_gnt.delete(); seen_dat.delete(); seen_cyc.delete();
    next_len = 3;
    for (int i = 0; i < N; i++) req_d[i] = 8'($urandom);
    req_v = 4'b1111;
    repeat (30) step();
    chk("all4_count", 32'(seen_gnt.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("all4_order", 32'(seen_gnt[k]), 32'(k));

    // Fairness: requesters 0 and 2 continuously valid
    do_reset();
    seen_gnt.delete(); seen_dat.delete(); seen_cyc.delete();
    next_len  = 2;
    hold_mask = 4'b0101;
    req_d[0]  = 8'h11;
    req_d[2]  = 8'h22;
    req_v     = 4'b0101;
    repeat (22) step();
    chk("fair_0", 32'(seen_gnt[0]), 32'd0);
    chk("fair_1", 32'(seen_gnt[1]), 32'd2);
    chk("fair_2", 32'(seen_gnt[2]), 32'd0);
    chk("fair_3", 32'(seen_gnt[3]), 32'd2);
    hold_mask = '0;
    req_v     = '0;
    repeat (12) step();

    // Transmitter busy while idle holds off the grant
    seen_gnt.delete(); seen_dat.delete(); seen_cyc.delete();
    force_busy = 1'b1;
    req_d[3]   = 8'h3C;
    req_v      = 4'b1000;
    repeat (5) step();
    chk("busy_hold_nogrant", 32'(seen_gnt.size()), 32'd0);
    force_busy = 1'b0;
    step();
    chk("busy_release_strobe", 32'(tx_data_valid), 32'd1);
    chk("busy_release_gid",    32'(grant_id),      32'd3);
    repeat (10) step();

    // Reset during WAIT_DONE, then arbitration restarts at requester 0
    seen_gnt.delete(); seen_dat.delete(); seen_cyc.delete();
    next_len = 8;
    req_d[1] = 8'h5A;
    req_v    = 4'b0010;
    wait_grant(10);
    repeat (4) step();
    drv_rst = 1'b1;
    step();
    drv_rst = 1'b0;
    chk("rst_valid",      32'(tx_data_valid), 32'd0);
    chk("rst_ready",      32'(req_ready),     32'd0);
    chk("rst_gid",        32'(grant_id),      32'd0);
    chk("rst_data",       32'(tx_data),       32'd0);
    chk("rst_sched_busy", 32'(sched_busy),    32'd0);
    next_len = 3;
    req_d[0] = 8'h0F;
    req_d[3] = 8'hF0;
    req_v    = 4'b1001;
    wait_grant(10);
    chk("rst_next_gid", 32'(seen_gnt[seen_gnt.size()-1]), 32'd0);
    req_v = '0;
    repeat (12) step();

    // Randomized traffic with stray transmitter busy while idle
    for (int c = 0; c < 400; c++) begin
      next_len = $urandom_range(1, 6);
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] && $urandom_range(0, 3) == 0) begin
          req_v[i] = 1'b1;
          req_d[i] = 8'($urandom);
        end else if (req_v[i] && $urandom_range(0, 15) == 0) begin
          req_v[i] = 1'b0;
        end
      end
      force_busy = !m_inflight && ($urandom_range(0, 7) == 0);
      step();
    end
    force_busy = 1'b0;
    req_v      = '0;
    repeat (12) step();

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // Transmitter never goes busy: watchdog drops the byte and moves on
    do_reset();
    seen_gnt.delete(); seen_dat.delete(); seen_cyc.delete();
    tout_cyc = -1;
    next_len = 0;
    req_v    = 4'b0011;
    wait_grant(10);
    next_len = 3;
    wait_grant(20);
    chk("tout_delay",    32'(tout_cyc - seen_cyc[0]), 32'd5);
    chk("tout_next_gid", 32'(seen_gnt[1]),            32'd1);
    repeat (10) step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmitter among up to NUM_REQ byte producers, such as the register-file readback and ALU result paths. It accepts one byte per grant over a valid/ready handshake, drives the transmitter's data and one-cycle data-valid strobe, and tracks the transmitter's Busy flag until the frame completes. It then grants the next requester. It sits between the system control logic and the UART Tx top.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 8: byte width per requester.
- TIMEOUT_CYCLES, 4: WAIT_BUSY cycle limit; used only with UART_TX_SCHED_TIMEOUT_EN.
- CLK  input  1  single clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req_valid  input  NUM_REQ  bit i high means requester i holds a byte; it stays high with stable data until that requester's Req_ready.
- Req_data  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- Req_ready  output  NUM_REQ  one-cycle accept pulse, at most one bit high.
- Tx_busy  input  1  Busy from the UART transmitter.
- Tx_data  output  DATA_WIDTH  byte to the transmitter, registered.
- Tx_data_valid  output  1  one-cycle strobe to the transmitter's Data_valid.
- Grant_id  output  clog2(NUM_REQ)  index of the last granted requester.
- Sched_busy  output  1  high whenever state is not IDLE.
- Timeout_err  output  1  one-cycle pulse when the transmitter fails to go busy; constant 0 without the macro.

## Operation
- State encoding: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE, arbitration condition: |Req_valid && !Tx_busy.
  - Search starts at index ptr and wraps modulo NUM_REQ; the first valid index g wins.
  - On the winning edge: Tx_data <= Req_data[g], Grant_id <= g, ptr <= (g+1) mod NUM_REQ, state -> ISSUE.
- IDLE with no valid request, or with Tx_busy high: stay in IDLE with no strobe.
- ISSUE, exactly one cycle:
  - Outputs: Tx_data_valid=1 and Req_ready[g]=1.
  - Next state: WAIT_BUSY.
- WAIT_BUSY:
  - Tx_busy=1: go to WAIT_DONE.
  - Tx_busy=0: stay, and count if the timeout is enabled.
- WAIT_DONE:
  - Tx_busy=0: go to IDLE.
  - Tx_busy=1: stay.
- Tx_data holds its value from grant until the next grant.
- Sched_busy is registered from the next state, so it is high from the ISSUE cycle through the last WAIT_DONE cycle.
- Requests arriving while not in IDLE wait; they are not queued internally.
- A requester dropping Req_valid before its grant is legal and simply loses arbitration.
- All other grant bits are ignored while one request is in flight.
- Reset (synchronous, effective at the next edge):
  - Reset values: state=IDLE, ptr=0, Tx_data=0, Tx_data_valid=0, Req_ready=0, Grant_id=0, Sched_busy=0, Timeout_err=0, timeout count=0.
  - Reset mid-frame drops the in-flight byte; that requester has already seen Req_ready and does not retry.

## Timing
- Grant edge k in IDLE: Tx_data_valid and Req_ready[g] are high during cycle k+1 only.
- The transmitter registers Busy, so Tx_busy is nominally high at cycle k+2; the scheduler enters WAIT_DONE on edge k+2.
- After Tx_busy falls, the scheduler takes one edge to reach IDLE and one more edge to grant.
  - The next Tx_data_valid therefore comes at least 2 cycles after Tx_busy is seen low.
  - This guarantees the transmitter has returned to Idle, because its Data_valid is ignored while Busy is high.
- Simultaneous requests: round-robin only, with no fixed priority beyond ptr.
  - After reset, requester 0 wins first.
  - A single continuously valid requester is granted on every frame.
- Arbitration is combinational from Req_valid and ptr; all outputs are registered.

## Configuration
- UART_TX_SCHED_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_BUSY and increments each WAIT_BUSY cycle with Tx_busy=0.
  - When it reaches TIMEOUT_CYCLES: Timeout_err is high for 1 cycle, state -> IDLE, and the byte is dropped; ptr has already advanced.
- Macro undefined: no counter; WAIT_BUSY waits indefinitely and Timeout_err is tied to 0.

## Test plan
- Single request: Req_valid=4'b0001, Req_data[7:0]=8'hA5, model Busy 1 cycle after the strobe for 11 cycles.
  - Required: Tx_data=8'hA5, Tx_data_valid exactly 1 cycle, Req_ready=4'b0001 in the same cycle, Grant_id=0, Sched_busy drops 1 cycle after Busy falls.
- All four requesters valid, each dropping valid after its ready.
  - Required: grant order 0,1,2,3; exactly one Tx_data_valid per frame; no strobe while Tx_busy=1.
- Fairness: requester 2 and requester 0 always valid.
  - Required: grants alternate 2,0,2,0 after the first grant to 0.
- Tx_busy held 1 in IDLE (transmitter still busy), Req_valid=4'b1000.
  - Required: no grant until Tx_busy=0, then Grant_id=3 on the following edge.
- Reset=1 asserted in WAIT_DONE.
  - Required: next cycle all outputs 0 and state IDLE; the following grant starts from requester 0.
- With UART_TX_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=4, Tx_busy stuck 0 after the strobe.
  - Required: Timeout_err pulses 4 cycles after entering WAIT_BUSY, then the next pending requester is granted.
